// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALUControl codes and execute-stage FSM encodings used by
//               alu_decoder and alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALUControl operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Execute-stage states. EXEC is folded into the output register: a
  // single-cycle op leaves the FSM in IDLE with out_valid set, which is what
  // allows back-to-back single-cycle ops at full rate.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_HOLD = 2'd3
  } alu_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_exec_unit_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_iter
// Description : Iterative shift-add multiplier. start loads the operands and
//               clears the accumulator; each following cycle retires one
//               multiplier bit. done is high during the final step, and p
//               then carries the low WIDTH bits of a*b as they will be
//               written on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] step_cnt;
  logic             busy;
  logic [WIDTH-1:0] acc_next;

  // One partial product per step: add the shifted multiplicand when the
  // current multiplier LSB is set.
  always_comb begin
    acc_next = acc + (b_sh[0] ? a_sh : '0);
  end

  assign done = busy && (step_cnt == LAST_STEP);
  assign p    = acc_next;

  // Operand shifting, accumulation and step counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
    end else if (start) begin
      a_sh     <= a;
      b_sh     <= b;
      acc      <= '0;
      step_cnt <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      if (done) begin
        busy     <= 1'b0;
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule : mul_iter
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready handshakes on both sides.
//               ADD/SUB/AND/OR/SLT and illegal codes complete in one cycle;
//               MUL runs through the iterative mul_iter over WIDTH cycles.
//               Result and NZCV/Illegal flags are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal
);

  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  alu_state_t       state;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic             add_v;
  logic             sub_v;
  logic             slt_bit;

  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_ovf;
  logic             nxt_illegal;
  logic             is_mul;

  // A new op is taken only from IDLE and only when the output slot is free
  // or being drained on this same edge.
  assign in_ready  = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;

  // WIDTH+1-bit adder and subtractor; SUB adds ~B with a carry-in of one so
  // the carry-out reads as "no borrow".
  always_comb begin
    add_sum = {1'b0, SrcA} + {1'b0, SrcB};
    sub_sum = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
    add_v   = (SrcA[MSB] == SrcB[MSB])  && (add_sum[MSB] != SrcA[MSB]);
    sub_v   = (SrcA[MSB] != SrcB[MSB])  && (sub_sum[MSB] != SrcA[MSB]);
    slt_bit = sub_sum[MSB] ^ sub_v;
  end

  // Select the single-cycle result and flags for the presented op code.
  always_comb begin
    nxt_result  = '0;
    nxt_carry   = 1'b0;
    nxt_ovf     = 1'b0;
    nxt_illegal = 1'b0;
    is_mul      = 1'b0;
    case (ALUControl)
      ALU_ADD: begin
        nxt_result = add_sum[MSB:0];
        nxt_carry  = add_sum[WIDTH];
        nxt_ovf    = add_v;
      end
      ALU_SUB: begin
        nxt_result = sub_sum[MSB:0];
        nxt_carry  = sub_sum[WIDTH];
        nxt_ovf    = sub_v;
      end
      ALU_AND: nxt_result = SrcA & SrcB;
      ALU_OR:  nxt_result = SrcA | SrcB;
      ALU_SLT: nxt_result = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_MUL: begin
        if (MUL_EN) begin
          is_mul = 1'b1;
        end else begin
          nxt_illegal = 1'b1;
        end
      end
      default: nxt_illegal = 1'b1;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      mul_iter #(
        .WIDTH (WIDTH)
      ) u_mul_iter (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (SrcA),
        .b     (SrcB),
        .done  (mul_done),
        .p     (mul_p)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_p    = '0;
    end
  endgenerate

  // FSM and output register: load on accept or MUL completion, drain on
  // out_ready, hold otherwise. Zero/Negative are registered alongside Result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      Illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state     <= ST_MUL;
              out_valid <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              Result    <= nxt_result;
              Zero      <= (nxt_result == '0);
              Negative  <= nxt_result[MSB];
              Carry     <= nxt_carry;
              Overflow  <= nxt_ovf;
              Illegal   <= nxt_illegal;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            Result    <= mul_p;
            Zero      <= (mul_p == '0);
            Negative  <= mul_p[MSB];
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Negative;
  logic        Carry;
  logic        Overflow;
  logic        Illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(
    .WIDTH  (32),
    .MUL_EN (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Zero       (Zero),
    .Negative   (Negative),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Flags packed as {V,C,N,Z,Illegal,out_valid}
  function automatic logic [31:0] flags();
    return {26'd0, Overflow, Carry, Negative, Zero, Illegal, out_valid};
  endfunction

  // Present one op for a single accepting edge, then drop in_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ALUControl = 3'b000;
    SrcA       = '0;
    SrcB       = '0;
    tick();
    tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_result",   Result,  32'd0);
    chk("reset_flags",    flags(), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD signed overflow: flags {V,C,N,Z,I,ov} = 1,0,1,0,0,1
    issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_ovf_result", Result,  32'h8000_0000);
    chk("add_ovf_flags",  flags(), 32'b101001);
    tick();
    chk("add_drop_valid", {31'd0, out_valid}, 32'd0);

    // ADD with carry-out wrapping to zero: C=1,Z=1
    issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("add_carry_result", Result,  32'h0000_0000);
    chk("add_carry_flags",  flags(), 32'b010101);

    // SUB equal operands: Z=1, C=1 (no borrow)
    issue(3'b001, 32'd5, 32'd5);
    chk("sub_eq_result", Result,  32'd0);
    chk("sub_eq_flags",  flags(), 32'b010101);

    // SUB with borrow: -2, C=0, N=1
    issue(3'b001, 32'd3, 32'd5);
    chk("sub_borrow_result", Result,  32'hFFFF_FFFE);
    chk("sub_borrow_flags",  flags(), 32'b001001);

    // SLT signed compare
    issue(3'b101, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("slt_neg_result", Result,  32'd1);
    chk("slt_neg_flags",  flags(), 32'b000001);
    issue(3'b101, 32'h0000_0001, 32'hFFFF_FFFF);
    chk("slt_pos_result", Result,  32'd0);
    chk("slt_pos_flags",  flags(), 32'b000101);

    // Logic ops
    issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
    chk("and_result", Result, 32'h0000_F000);
    issue(3'b011, 32'h0000_F0F0, 32'h0000_FF00);
    chk("or_result", Result, 32'h0000_FFF0);
    tick();

    // MUL: busy for 32 cycles, then result held while out_ready=0
    issue(3'b100, 32'h0001_2345, 32'h0000_0100);
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("mul_busy_ready_%0d", i), {31'd0, in_ready},  32'd0);
      chk($sformatf("mul_busy_valid_%0d", i), {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("mul_result", Result,  32'h0123_4500);
    chk("mul_flags",  flags(), 32'b000001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("mul_hold_result_%0d", i), Result, 32'h0123_4500);
      chk($sformatf("mul_hold_flags_%0d", i),  flags(), 32'b000001);
      chk($sformatf("mul_hold_ready_%0d", i),  {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("mul_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("mul_drain_ready", {31'd0, in_ready},  32'd1);

    // Reset during MUL step 10 aborts the op
    issue(3'b100, 32'd7, 32'd9);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mul_abort_valid",  {31'd0, out_valid}, 32'd0);
    chk("mul_abort_result", Result, 32'd0);
    chk("mul_abort_ready",  {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 35; i++) tick();
    chk("mul_abort_no_result", {31'd0, out_valid}, 32'd0);
    issue(3'b000, 32'd2, 32'd3);
    chk("add_after_abort", Result, 32'd5);
    chk("add_after_abort_valid", {31'd0, out_valid}, 32'd1);

    // Streaming ADDs: one result per cycle, in order
    ALUControl = 3'b000;
    in_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SrcA = 32'(i * 10 + 1);
      SrcB = 32'(i + 2);
      tick();
      chk($sformatf("stream_result_%0d", i), Result, 32'(i * 11 + 3));
      chk($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream_ready_%0d", i), {31'd0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", {31'd0, out_valid}, 32'd0);

    // Output stall ignores a new op, then same-edge replacement
    out_ready = 1'b0;
    issue(3'b000, 32'd10, 32'd20);
    chk("stall_first", Result, 32'd30);
    ALUControl = 3'b011;
    SrcA       = 32'h0000_0F00;
    SrcB       = 32'h0000_00F0;
    in_valid   = 1'b1;
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk("stall_hold", Result, 32'd30);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("replace_result", Result, 32'h0000_0FF0);
    chk("replace_valid",  {31'd0, out_valid}, 32'd1);

    // Illegal codes: Result=0, Zero=1, Illegal=1
    issue(3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("illegal_111_result", Result,  32'd0);
    chk("illegal_111_flags",  flags(), 32'b000111);
    issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("illegal_110_flags",  flags(), 32'b000111);
    issue(3'b000, 32'd1, 32'd1);
    chk("legal_clears_illegal", flags(), 32'b000001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_exec_unit
`default_nettype wire
